// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the pipeline/predictor side and the branch resolve unit.
// The master drives ID/MEM branch information; the slave (resolve unit) returns redirect/update/perf.
interface branch_resolve_unit_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 stall;
  logic                 id_branch;
  logic                 id_prediction;
  logic [31:0]          id_pc;
  logic [31:0]          id_target;
  logic                 mem_branch;
  logic                 mem_taken;
  logic [31:0]          mem_target;
  logic                 redirect;
  logic [31:0]          redirect_pc;
  logic                 flush;
  logic                 upd_valid;
  logic [31:0]          upd_pc;
  logic                 upd_taken;
  logic [CNT_WIDTH-1:0] cnt_branches;
  logic [CNT_WIDTH-1:0] cnt_mispred;
  logic                 protocol_err;

  modport master (
    output stall, id_branch, id_prediction, id_pc, id_target,
    output mem_branch, mem_taken, mem_target,
    input  redirect, redirect_pc, flush, upd_valid, upd_pc, upd_taken,
    input  cnt_branches, cnt_mispred, protocol_err
  );

  modport slave (
    input  stall, id_branch, id_prediction, id_pc, id_target,
    input  mem_branch, mem_taken, mem_target,
    output redirect, redirect_pc, flush, upd_valid, upd_pc, upd_taken,
    output cnt_branches, cnt_mispred, protocol_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries ID-stage branch predictions to MEM, resolves them against the actual outcome, and
// issues redirect/flush to fetch plus update strobes to the predictor. Keeps saturating counters.
module branch_resolve_unit #(
  parameter int unsigned PIPE_DEPTH   = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned HeadIdx = PIPE_DEPTH - 1;
  localparam int unsigned FcW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef struct packed {
    logic        v;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] tgt;
  } entry_t;

  typedef enum logic {StIdle, StFlush} state_e;

  state_e               state_q, state_d;
  logic [FcW-1:0]       fcnt_q, fcnt_d;
  entry_t               pipe_q [PIPE_DEPTH];

  logic                 redirect_q;
  logic [31:0]          redirect_pc_q;
  logic                 upd_valid_q;
  logic [31:0]          upd_pc_q;
  logic                 upd_taken_q;
  logic [CNT_WIDTH-1:0] cnt_br_q;
  logic [CNT_WIDTH-1:0] cnt_mis_q;
  logic                 perr_q;

  logic   advance;
  logic   in_flush;
  logic   resolve;
  logic   mis;
  logic   proto_hit;
  logic   kill;
  entry_t head;

  always_comb begin
    head      = pipe_q[HeadIdx];
    advance   = ~bus.stall;
    in_flush  = (state_q == StFlush);
    resolve   = advance & bus.mem_branch & head.v & ~in_flush;
    mis       = (head.pred != bus.mem_taken) |
                (bus.mem_taken & (head.tgt != bus.mem_target));
    proto_hit = advance & bus.mem_branch & (~head.v | in_flush);
    // A mispredict kills the ID entry captured on the same edge and everything younger.
    kill      = in_flush | (resolve & mis);
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StIdle: begin
        if (resolve && mis) begin
          state_d = StFlush;
          fcnt_d  = FcW'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: begin
        if (advance) begin
          if (fcnt_q == '0) begin
            state_d = StIdle;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        pipe_q[k] <= '0;
      end
    end else if (advance) begin
      pipe_q[0] <= '{v:    bus.id_branch & ~kill,
                     pred: bus.id_prediction,
                     pc:   bus.id_pc,
                     tgt:  bus.id_target};
      for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
        pipe_q[k]   <= pipe_q[k-1];
        pipe_q[k].v <= pipe_q[k-1].v & ~kill;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      cnt_br_q      <= '0;
      cnt_mis_q     <= '0;
      perr_q        <= 1'b0;
    end else begin
      // Pulses are recomputed every edge, so a stall cannot stretch them.
      redirect_q  <= resolve & mis;
      upd_valid_q <= resolve;
      perr_q      <= perr_q | proto_hit;
      if (resolve) begin
        upd_pc_q    <= head.pc;
        upd_taken_q <= bus.mem_taken;
        if (cnt_br_q != '1) cnt_br_q <= cnt_br_q + 1'b1;
        if (mis) begin
          redirect_pc_q <= bus.mem_taken ? bus.mem_target : head.pc + 32'd4;
          if (cnt_mis_q != '1) cnt_mis_q <= cnt_mis_q + 1'b1;
        end
      end
    end
  end

  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.flush        = in_flush;
  assign bus.upd_valid    = upd_valid_q;
  assign bus.upd_pc       = upd_pc_q;
  assign bus.upd_taken    = upd_taken_q;
  assign bus.cnt_branches = cnt_br_q;
  assign bus.cnt_mispred  = cnt_mis_q;
  assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a tag-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned FCYC  = 2;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_WIDTH(CW)) bus ();

  branch_resolve_unit #(
    .PIPE_DEPTH  (DEPTH),
    .FLUSH_CYCLES(FCYC),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: each ID branch is tagged with the index of the unstalled edge that captured it.
  // The branch resolved at edge n is the one tagged n-DEPTH, valid only if no kill edge since.
  typedef struct {
    bit          pred;
    bit [31:0]   pc;
    bit [31:0]   tgt;
  } id_rec_t;

  id_rec_t   ids [int];
  int        adv = 0;
  int        last_kill = 0;
  int        flush_left = 0;
  bit        e_redirect = 0;
  bit [31:0] e_rpc = 0;
  bit        e_upd = 0;
  bit [31:0] e_upc = 0;
  bit        e_ut = 0;
  int        e_cb = 0;
  int        e_cm = 0;
  bit        e_perr = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ids.delete();
      adv = 0; last_kill = 0; flush_left = 0;
      e_redirect = 0; e_rpc = 0; e_upd = 0; e_upc = 0; e_ut = 0;
      e_cb = 0; e_cm = 0; e_perr = 0;
    end else begin
      e_redirect = 0;
      e_upd      = 0;
      if (!bus.stall) begin
        int  htag;
        bit  infl;
        bit  m;
        adv++;
        infl = (flush_left > 0);
        htag = adv - int'(DEPTH);
        m    = 0;
        if (bus.mem_branch) begin
          if (infl || htag <= last_kill || !ids.exists(htag)) begin
            e_perr = 1;
          end else begin
            id_rec_t h;
            h = ids[htag];
            m = (h.pred != bus.mem_taken) || (bus.mem_taken && h.tgt != bus.mem_target);
            e_upd = 1; e_upc = h.pc; e_ut = bus.mem_taken;
            e_cb  = (e_cb >= CMAX) ? CMAX : e_cb + 1;
            if (m) begin
              e_redirect = 1;
              e_rpc = bus.mem_taken ? bus.mem_target : h.pc + 32'd4;
              e_cm  = (e_cm >= CMAX) ? CMAX : e_cm + 1;
            end
          end
        end
        if (infl) flush_left--;
        if (infl || m) last_kill = adv;
        if (m) flush_left = FCYC;
        if (bus.id_branch) ids[adv] = '{bus.id_prediction, bus.id_pc, bus.id_target};
      end
    end
  end

  always @(negedge clk) begin
    chk("redirect",     32'(bus.redirect),     32'(e_redirect));
    chk("redirect_pc",  bus.redirect_pc,       e_rpc);
    chk("flush",        32'(bus.flush),        32'(flush_left > 0));
    chk("upd_valid",    32'(bus.upd_valid),    32'(e_upd));
    chk("upd_pc",       bus.upd_pc,            e_upc);
    chk("upd_taken",    32'(bus.upd_taken),    32'(e_ut));
    chk("cnt_branches", 32'(bus.cnt_branches), 32'(e_cb));
    chk("cnt_mispred",  32'(bus.cnt_mispred),  32'(e_cm));
    chk("protocol_err", 32'(bus.protocol_err), 32'(e_perr));
  end

  // Inputs change 2 time units after each rising edge, well clear of sampling.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_id(input bit pred, input logic [31:0] pc, input logic [31:0] tgt);
    bus.id_branch = 1; bus.id_prediction = pred; bus.id_pc = pc; bus.id_target = tgt;
    step();
    bus.id_branch = 0;
  endtask

  task automatic resolve(input bit taken, input logic [31:0] tgt);
    bus.mem_branch = 1; bus.mem_taken = taken; bus.mem_target = tgt;
    step();
    bus.mem_branch = 0;
  endtask

  initial begin
    bus.stall = 0; bus.id_branch = 0; bus.id_prediction = 0; bus.id_pc = 0; bus.id_target = 0;
    bus.mem_branch = 0; bus.mem_taken = 0; bus.mem_target = 0;
    step(); step();
    chk("reset_flush", 32'(bus.flush), 32'd0);
    chk("reset_cnt",   32'(bus.cnt_branches), 32'd0);
    reset_n = 1;
    step();

    // 1: correct not-taken prediction
    send_id(0, 32'h100, 32'h0);
    step();
    resolve(0, 32'h0);
    chk("t1_upd_valid", 32'(bus.upd_valid), 32'd1);
    chk("t1_upd_pc",    bus.upd_pc, 32'h100);
    chk("t1_redirect",  32'(bus.redirect), 32'd0);
    chk("t1_cnt_br",    32'(bus.cnt_branches), 32'd1);
    step();
    chk("t1_pulse_end", 32'(bus.upd_valid), 32'd0);

    // 1b: back-to-back correct branches
    send_id(0, 32'h140, 32'h0);
    send_id(1, 32'h144, 32'h1A0);
    resolve(0, 32'h0);
    resolve(1, 32'h1A0);
    chk("t1b_upd_pc", bus.upd_pc, 32'h144);
    chk("t1b_cnt_br", 32'(bus.cnt_branches), 32'd3);
    step();

    // 2: predicted not-taken, actually taken
    send_id(0, 32'h200, 32'h0);
    step();
    resolve(1, 32'h180);
    chk("t2_redirect", 32'(bus.redirect), 32'd1);
    chk("t2_rpc",      bus.redirect_pc, 32'h180);
    chk("t2_flush0",   32'(bus.flush), 32'd1);
    chk("t2_cnt_mis",  32'(bus.cnt_mispred), 32'd1);
    step();
    chk("t2_flush1",   32'(bus.flush), 32'd1);
    chk("t2_red_end",  32'(bus.redirect), 32'd0);
    step();
    chk("t2_flush2",   32'(bus.flush), 32'd0);

    // 3a: predicted taken, actually not taken -> pc+4
    send_id(1, 32'h2FC, 32'h300);
    step();
    resolve(0, 32'h0);
    chk("t3a_rpc", bus.redirect_pc, 32'h300);
    step(); step();
    // 3b: direction right, target wrong
    send_id(1, 32'h3F0, 32'h400);
    step();
    resolve(1, 32'h404);
    chk("t3b_rpc", bus.redirect_pc, 32'h404);
    chk("t3b_mis", 32'(bus.cnt_mispred), 32'd3);
    step(); step();

    // 4: stall held 3 cycles mid-flush; ID branches during flush are dropped
    send_id(0, 32'h600, 32'h0);
    step();
    resolve(1, 32'h700);
    bus.id_branch = 1; bus.id_pc = 32'h800;
    step();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_flush_stall", 32'(bus.flush), 32'd1);
    end
    bus.stall = 0; bus.id_pc = 32'h804;
    step();
    bus.id_branch = 0;
    chk("t4_flush_end", 32'(bus.flush), 32'd0);

    // 5: mem_branch where the flushed entry would have reached head -> protocol error
    step();
    resolve(1, 32'h900);
    chk("t5_perr",   32'(bus.protocol_err), 32'd1);
    chk("t5_upd",    32'(bus.upd_valid), 32'd0);
    chk("t5_cnt_br", 32'(bus.cnt_branches), 32'd7);
    step(); step();
    chk("t5_sticky", 32'(bus.protocol_err), 32'd1);

    // Saturation: enough mispredicts to pin both counters at all-ones
    for (int i = 0; i < 14; i++) begin
      send_id(0, 32'h1000 + 32'(i * 16), 32'h0);
      step();
      resolve(1, 32'h2000 + 32'(i * 16));
      step(); step();
    end
    chk("sat_cnt_br",  32'(bus.cnt_branches), 32'hF);
    chk("sat_cnt_mis", 32'(bus.cnt_mispred), 32'hF);

    // 6: async reset during flush
    send_id(0, 32'hA00, 32'h0);
    step();
    resolve(1, 32'hA80);
    chk("t6_flush_pre", 32'(bus.flush), 32'd1);
    #1;
    reset_n = 0;
    #1;
    chk("t6_flush_rst", 32'(bus.flush), 32'd0);
    chk("t6_red_rst",   32'(bus.redirect), 32'd0);
    chk("t6_perr_rst",  32'(bus.protocol_err), 32'd0);
    step();
    reset_n = 1;
    step();
    chk("t6_idle", 32'(bus.flush), 32'd0);
    send_id(0, 32'hB00, 32'h0);
    step();
    resolve(0, 32'h0);
    chk("t6_upd_pc", bus.upd_pc, 32'hB00);
    chk("t6_cnt_br", 32'(bus.cnt_branches), 32'd1);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
